lsu_mem_stage: RTL and testbench



---
 rtl/riscv_def.sv | 51 +++++
 rtl/lsu_load_align.sv | 29 ++
 rtl/lsu_mem_stage.sv | 149 ++++++++++++++
 tb/tb_lsu_mem_stage.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_def.sv
// Shared core definitions: ALU and LSU operation codes, LSU FSM state encoding
// and small LSU op-decode helpers.
package riscv_def;

  // ALU operation codes (execute stage)
  localparam logic [3:0] AluOp_ADD  = 4'h0;
  localparam logic [3:0] AluOp_SUB  = 4'h1;
  localparam logic [3:0] AluOp_AND  = 4'h2;
  localparam logic [3:0] AluOp_OR   = 4'h3;
  localparam logic [3:0] AluOp_XOR  = 4'h4;
  localparam logic [3:0] AluOp_SLL  = 4'h5;
  localparam logic [3:0] AluOp_SRL  = 4'h6;
  localparam logic [3:0] AluOp_SRA  = 4'h7;
  localparam logic [3:0] AluOp_SLT  = 4'h8;
  localparam logic [3:0] AluOp_SLTU = 4'h9;

  // LSU operation codes; codes above LsuOp_SW behave as LsuOp_NONE
  localparam logic [3:0] LsuOp_NONE = 4'h0;
  localparam logic [3:0] LsuOp_LB   = 4'h1;
  localparam logic [3:0] LsuOp_LH   = 4'h2;
  localparam logic [3:0] LsuOp_LW   = 4'h3;
  localparam logic [3:0] LsuOp_LBU  = 4'h4;
  localparam logic [3:0] LsuOp_LHU  = 4'h5;
  localparam logic [3:0] LsuOp_SB   = 4'h6;
  localparam logic [3:0] LsuOp_SH   = 4'h7;
  localparam logic [3:0] LsuOp_SW   = 4'h8;

  typedef enum logic [1:0] {
    LsuSt_IDLE = 2'd0,
    LsuSt_REQ  = 2'd1,
    LsuSt_WAIT = 2'd2,
    LsuSt_RESP = 2'd3
  } lsu_state_e;

  function automatic logic lsu_is_load(input logic [3:0] op);
    return op inside {LsuOp_LB, LsuOp_LH, LsuOp_LW, LsuOp_LBU, LsuOp_LHU};
  endfunction

  function automatic logic lsu_is_store(input logic [3:0] op);
    return op inside {LsuOp_SB, LsuOp_SH, LsuOp_SW};
  endfunction

  function automatic logic lsu_is_half(input logic [3:0] op);
    return op inside {LsuOp_LH, LsuOp_LHU, LsuOp_SH};
  endfunction

  function automatic logic lsu_is_word(input logic [3:0] op);
    return op inside {LsuOp_LW, LsuOp_SW};
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the byte/half lane addressed by addr[1:0] out of
// the returned memory word and sign- or zero-extends it per lsu_op.
// Ports: rdata (memory word), addr (low address bits), lsu_op (load code),
//        data (extended 32-bit result).
module lsu_load_align
  import riscv_def::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [3:0]  lsu_op,
  output logic [31:0] data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = rdata[{addr, 3'b000} +: 8];
    half_val = addr[1] ? rdata[31:16] : rdata[15:0];
    case (lsu_op)
      LsuOp_LB:  data = {{24{byte_val[7]}}, byte_val};
      LsuOp_LBU: data = {24'h0, byte_val};
      LsuOp_LH:  data = {{16{half_val[15]}}, half_val};
      LsuOp_LHU: data = {16'h0, half_val};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory stage behind the execute ALU. Accepts one op at a time, performs a
// single load/store over a req/gnt/rvalid data-memory port and emits a
// one-cycle writeback pulse (load data or alu_result pass-through).
// Ports: clk/rst (sync active-high); ex_valid/ex_ready/lsu_op/alu_result/
//        store_data/rd_in from execute; dmem_* memory port; wb_valid/wb_rd/
//        wb_data writeback; misalign_exc trap pulse.
// Build option LSU_MISALIGN_TRAP_EN: misaligned ops raise misalign_exc and
// skip the bus; otherwise the address is aligned down and the access proceeds.
module lsu_mem_stage
  import riscv_def::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [3:0]      lsu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic [RD_W-1:0] rd_in,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign_exc
);

  lsu_state_e      state_q, state_d;
  logic [3:0]      op_q;
  logic [XLEN-1:0] addr_q, sdata_q, wb_data_q;
  logic [RD_W-1:0] rd_q;
  logic [XLEN-1:0] addr_in, load_data;
  logic            accept, is_mem_in, trap_in;
  logic [1:0]      lane;

  assign accept    = ex_valid && (state_q == LsuSt_IDLE);
  assign is_mem_in = lsu_is_load(lsu_op) || lsu_is_store(lsu_op);
  assign lane      = addr_q[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_in, exc_q;
  assign misalign_in  = (lsu_is_half(lsu_op) && alu_result[0]) ||
                        (lsu_is_word(lsu_op) && (alu_result[1:0] != 2'b00));
  assign trap_in      = accept && is_mem_in && misalign_in;
  assign addr_in      = alu_result;
  assign misalign_exc = exc_q;

  always_ff @(posedge clk) begin
    if (rst) exc_q <= 1'b0;
    else     exc_q <= trap_in;
  end
`else
  assign trap_in      = 1'b0;
  assign misalign_exc = 1'b0;

  // Misaligned accesses silently drop the offending low address bits.
  always_comb begin
    addr_in = alu_result;
    if (lsu_is_half(lsu_op)) addr_in[0]   = 1'b0;
    if (lsu_is_word(lsu_op)) addr_in[1:0] = 2'b00;
  end
`endif

  lsu_load_align u_load_align (
    .rdata  (dmem_rdata),
    .addr   (lane),
    .lsu_op (op_q),
    .data   (load_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LsuSt_IDLE: begin
        if (accept) begin
          if (!is_mem_in)    state_d = LsuSt_RESP;
          else if (!trap_in) state_d = LsuSt_REQ;
        end
      end
      LsuSt_REQ: begin
        if (dmem_gnt) state_d = lsu_is_store(op_q) ? LsuSt_IDLE : LsuSt_WAIT;
      end
      LsuSt_WAIT: begin
        if (dmem_rvalid) state_d = LsuSt_RESP;
      end
      LsuSt_RESP: state_d = LsuSt_IDLE;
      default:    state_d = LsuSt_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LsuSt_IDLE;
      op_q      <= LsuOp_NONE;
      addr_q    <= '0;
      sdata_q   <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= lsu_op;
        addr_q  <= addr_in;
        sdata_q <= store_data;
        rd_q    <= rd_in;
        if (!is_mem_in) wb_data_q <= alu_result;
      end
      if (state_q == LsuSt_WAIT && dmem_rvalid) wb_data_q <= load_data;
    end
  end

  // Bus outputs are only driven while requesting so the idle port reads as 0.
  always_comb begin
    ex_ready   = (state_q == LsuSt_IDLE);
    dmem_req   = (state_q == LsuSt_REQ);
    dmem_we    = dmem_req && lsu_is_store(op_q);
    dmem_addr  = '0;
    dmem_be    = 4'b0000;
    dmem_wdata = '0;
    if (dmem_req) begin
      dmem_addr = {addr_q[XLEN-1:2], 2'b00};
      case (op_q)
        LsuOp_LB, LsuOp_LBU, LsuOp_SB: dmem_be = 4'b0001 << lane;
        LsuOp_LH, LsuOp_LHU, LsuOp_SH: dmem_be = 4'b0011 << {lane[1], 1'b0};
        LsuOp_LW, LsuOp_SW:            dmem_be = 4'b1111;
        default:                       dmem_be = 4'b0000;
      endcase
      case (op_q)
        LsuOp_SB: dmem_wdata = {4{sdata_q[7:0]}};
        LsuOp_SH: dmem_wdata = {2{sdata_q[15:0]}};
        LsuOp_SW: dmem_wdata = sdata_q;
        default:  dmem_wdata = '0;
      endcase
    end
    wb_valid = (state_q == LsuSt_RESP);
    wb_rd    = wb_valid ? rd_q : '0;
    wb_data  = wb_valid ? wb_data_q : '0;
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed vector table, hand-written
// reset/spurious-rvalid sequences and randomized ops against a reference model.
// Cycle numbering: the cycle in which the op is accepted is cycle 0, so a NONE
// op writes back in cycle 1 (the second cycle counting the acceptance cycle).
module tb_lsu_mem_stage;
  import riscv_def::*;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [3:0]  lsu_op;
  logic [31:0] alu_result, store_data;
  logic [4:0]  rd_in;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, misalign_exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  lsu_mem_stage #(.XLEN(32), .RD_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .lsu_op       (lsu_op),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .rd_in        (rd_in),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .misalign_exc (misalign_exc)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          gnt_dly;  // REQ cycles without gnt before the granting one
    int          rv_dly;   // WAIT cycles without rvalid before the valid one
  } txn_t;

  typedef struct {
    int          req_cyc;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    bit          unstable;
    int          wb_cnt;
    int          wb_cyc;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    int          exc_cnt;
    int          exc_cyc;
    int          done_cyc;  // first cycle ex_ready is high again
  } obs_t;

  typedef struct {
    txn_t        t;
    bit          x_req;
    logic [31:0] x_addr;
    logic [3:0]  x_be;
    logic [31:0] x_wdata;
    bit          x_wb;
    logic [31:0] x_wb_data;
    bit          x_exc;
  } vec_t;

  // Reference model: what an op should do, from access size and byte arithmetic.
  function automatic obs_t model(input txn_t t);
    obs_t e;
    longint unsigned size, a, ea, lane, mask, v, w;
    bit st, sgn;
    e = '{default: 0};
    size = 0; st = 0; sgn = 0;
    case (t.op)
      LsuOp_LB:  begin size = 1; sgn = 1; end
      LsuOp_LBU: size = 1;
      LsuOp_LH:  begin size = 2; sgn = 1; end
      LsuOp_LHU: size = 2;
      LsuOp_LW:  size = 4;
      LsuOp_SB:  begin size = 1; st = 1; end
      LsuOp_SH:  begin size = 2; st = 1; end
      LsuOp_SW:  begin size = 4; st = 1; end
      default:   size = 0;
    endcase
    if (size == 0) begin
      e.wb_cnt = 1; e.wb_cyc = 1; e.wb_data = t.addr; e.wb_rd = t.rd; e.done_cyc = 2;
      return e;
    end
    a = t.addr;
    if (Trap && (a % size) != 0) begin
      e.exc_cnt = 1; e.exc_cyc = 1; e.done_cyc = 1;
      return e;
    end
    ea   = a - (a % size);
    lane = ea % 4;
    mask = (64'd1 << (8 * size)) - 1;
    e.req_cyc = t.gnt_dly + 1;
    e.addr = 32'(ea - lane);
    e.be   = 4'(((64'd1 << size) - 1) << lane);
    e.we   = st;
    if (st) begin
      v = t.sd & mask;
      w = 0;
      for (int k = 0; k < int'(4 / size); k++) w = w | (v << (8 * size * k));
      e.wdata = 32'(w);
      e.done_cyc = t.gnt_dly + 2;
      return e;
    end
    v = (64'(t.rdata) >> (8 * lane)) & mask;
    if (sgn && v > mask / 2) v = v + 64'h1_0000_0000 - (mask + 1);
    e.wb_cnt = 1; e.wb_data = 32'(v); e.wb_rd = t.rd;
    e.wb_cyc = t.gnt_dly + t.rv_dly + 3;
    e.done_cyc = t.gnt_dly + t.rv_dly + 4;
    return e;
  endfunction

  // Issues one op, plays the memory side and records what the DUT did.
  task automatic run_op(input txn_t t, output obs_t o);
    bit rv_pend;
    int rv_t;
    o = '{default: 0};
    rv_pend = 0; rv_t = 0;
    @(negedge clk);
    ex_valid = 1'b1; lsu_op = t.op; alu_result = t.addr; store_data = t.sd; rd_in = t.rd;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      ex_valid = 1'b0;
      lsu_op = 4'($urandom); alu_result = $urandom; store_data = $urandom; rd_in = 5'($urandom);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      if (misalign_exc) begin o.exc_cnt++; o.exc_cyc = cyc; end
      if (wb_valid) begin
        o.wb_cnt++; o.wb_cyc = cyc; o.wb_data = wb_data; o.wb_rd = wb_rd;
      end
      if (rv_pend) begin
        if (rv_t == t.rv_dly) begin
          dmem_rvalid = 1'b1; dmem_rdata = t.rdata; rv_pend = 0;
        end else rv_t++;
      end
      if (dmem_req) begin
        if (o.req_cyc == 0) begin
          o.addr = dmem_addr; o.be = dmem_be; o.we = dmem_we; o.wdata = dmem_wdata;
        end else if (o.addr !== dmem_addr || o.be !== dmem_be || o.we !== dmem_we ||
                     o.wdata !== dmem_wdata) begin
          o.unstable = 1;
        end
        o.req_cyc++;
        if (o.req_cyc == t.gnt_dly + 1) begin
          dmem_gnt = 1'b1;
          if (!dmem_we) begin rv_pend = 1; rv_t = 0; end
        end
      end
      if (ex_ready && o.done_cyc == 0) o.done_cyc = cyc;
      if (o.done_cyc != 0 && cyc >= o.done_cyc + 2) break;
    end
  endtask

  task automatic compare(input string tag, input obs_t o, input obs_t e);
    chk({tag, ".req_cycles"}, o.req_cyc, e.req_cyc);
    if (e.req_cyc > 0) begin
      chk({tag, ".dmem_addr"}, o.addr, e.addr);
      chk({tag, ".dmem_be"}, o.be, e.be);
      chk({tag, ".dmem_we"}, o.we, e.we);
      chk({tag, ".req_unstable"}, o.unstable, 0);
      if (e.we) chk({tag, ".dmem_wdata"}, o.wdata, e.wdata);
    end
    chk({tag, ".wb_count"}, o.wb_cnt, e.wb_cnt);
    if (e.wb_cnt > 0) begin
      chk({tag, ".wb_cycle"}, o.wb_cyc, e.wb_cyc);
      chk({tag, ".wb_data"}, o.wb_data, e.wb_data);
      chk({tag, ".wb_rd"}, o.wb_rd, e.wb_rd);
    end
    chk({tag, ".exc_count"}, o.exc_cnt, e.exc_cnt);
    if (e.exc_cnt > 0) chk({tag, ".exc_cycle"}, o.exc_cyc, e.exc_cyc);
    chk({tag, ".ready_cycle"}, o.done_cyc, e.done_cyc);
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                              input logic [31:0] rdata, input logic [4:0] rd, input int g,
                              input int r, input bit xreq, input logic [31:0] xaddr,
                              input logic [3:0] xbe, input logic [31:0] xwdata, input bit xwb,
                              input logic [31:0] xwbd, input bit xexc);
    vec_t v;
    v.t = '{op: op, addr: addr, sd: sd, rdata: rdata, rd: rd, gnt_dly: g, rv_dly: r};
    v.x_req = xreq; v.x_addr = xaddr; v.x_be = xbe; v.x_wdata = xwdata;
    v.x_wb = xwb; v.x_wb_data = xwbd; v.x_exc = xexc;
    return v;
  endfunction

  vec_t vecs[12];
  obs_t o;
  int   wb_seen;

  initial begin
    vecs[0]  = mk(LsuOp_NONE, 32'h1234_5678, 32'h0, 32'h0, 5'd7, 0, 0,
                  0, 32'h0, 4'h0, 32'h0, 1, 32'h1234_5678, 0);
    vecs[1]  = mk(LsuOp_LB, 32'h103, 32'h0, 32'h80FF_FF7F, 5'd3, 0, 0,
                  1, 32'h100, 4'b1000, 32'h0, 1, 32'hFFFF_FF80, 0);
    vecs[2]  = mk(LsuOp_LBU, 32'h103, 32'h0, 32'h80FF_FF7F, 5'd4, 0, 0,
                  1, 32'h100, 4'b1000, 32'h0, 1, 32'h0000_0080, 0);
    vecs[3]  = mk(LsuOp_SH, 32'h202, 32'hAAAA_BEEF, 32'h0, 5'd5, 2, 0,
                  1, 32'h200, 4'b1100, 32'hBEEF_BEEF, 0, 32'h0, 0);
    vecs[4]  = mk(LsuOp_LW, 32'h400, 32'h0, 32'hDEAD_BEEF, 5'd9, 0, 5,
                  1, 32'h400, 4'b1111, 32'h0, 1, 32'hDEAD_BEEF, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[5]  = mk(LsuOp_LW, 32'h301, 32'h0, 32'h1122_3344, 5'd10, 0, 0,
                  0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 1);
    vecs[11] = mk(LsuOp_LH, 32'h103, 32'h0, 32'h7F00_0000, 5'd16, 1, 1,
                  0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 1);
`else
    vecs[5]  = mk(LsuOp_LW, 32'h301, 32'h0, 32'h1122_3344, 5'd10, 0, 0,
                  1, 32'h300, 4'b1111, 32'h0, 1, 32'h1122_3344, 0);
    vecs[11] = mk(LsuOp_LH, 32'h103, 32'h0, 32'h7F00_0000, 5'd16, 1, 1,
                  1, 32'h100, 4'b1100, 32'h0, 1, 32'h0000_7F00, 0);
`endif
    vecs[6]  = mk(LsuOp_LH, 32'h106, 32'h0, 32'h8001_7FFF, 5'd11, 1, 2,
                  1, 32'h104, 4'b1100, 32'h0, 1, 32'hFFFF_8001, 0);
    vecs[7]  = mk(LsuOp_LHU, 32'h104, 32'h0, 32'h8001_9234, 5'd12, 0, 1,
                  1, 32'h104, 4'b0011, 32'h0, 1, 32'h0000_9234, 0);
    vecs[8]  = mk(LsuOp_SB, 32'h55, 32'h1234_56A5, 32'h0, 5'd13, 0, 0,
                  1, 32'h54, 4'b0010, 32'hA5A5_A5A5, 0, 32'h0, 0);
    vecs[9]  = mk(LsuOp_SW, 32'h60, 32'hCAFE_F00D, 32'h0, 5'd14, 1, 0,
                  1, 32'h60, 4'b1111, 32'hCAFE_F00D, 0, 32'h0, 0);
    vecs[10] = mk(4'hF, 32'hABCD_0123, 32'h0, 32'h0, 5'd15, 0, 0,
                  0, 32'h0, 4'h0, 32'h0, 1, 32'hABCD_0123, 0);

    // Reset state
    rst = 1'b1; ex_valid = 1'b0; lsu_op = 4'h0; alu_result = '0; store_data = '0; rd_in = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("reset.ex_ready", ex_ready, 1);
    chk("reset.dmem_req", dmem_req, 0);
    chk("reset.dmem_we", dmem_we, 0);
    chk("reset.dmem_addr", dmem_addr, 0);
    chk("reset.dmem_be", dmem_be, 0);
    chk("reset.dmem_wdata", dmem_wdata, 0);
    chk("reset.wb_valid", wb_valid, 0);
    chk("reset.wb_rd", wb_rd, 0);
    chk("reset.wb_data", wb_data, 0);
    chk("reset.misalign_exc", misalign_exc, 0);
    rst = 1'b0;

    // Directed vectors
    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_op(vecs[i].t, o);
      chk({tag, ".x_req"}, (o.req_cyc > 0), vecs[i].x_req);
      if (vecs[i].x_req) begin
        chk({tag, ".x_addr"}, o.addr, vecs[i].x_addr);
        chk({tag, ".x_be"}, o.be, vecs[i].x_be);
        if (lsu_is_store(vecs[i].t.op)) chk({tag, ".x_wdata"}, o.wdata, vecs[i].x_wdata);
      end
      chk({tag, ".x_wb"}, (o.wb_cnt > 0), vecs[i].x_wb);
      if (vecs[i].x_wb) chk({tag, ".x_wb_data"}, o.wb_data, vecs[i].x_wb_data);
      chk({tag, ".x_exc"}, (o.exc_cnt > 0), vecs[i].x_exc);
      compare(tag, o, model(vecs[i].t));
    end

    // Spurious rvalid while idle must not write back
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    wb_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      dmem_rvalid = 1'b0;
      if (wb_valid) wb_seen++;
    end
    chk("idle_rvalid.wb_count", wb_seen, 0);

    // Reset while waiting for load data
    @(negedge clk);
    ex_valid = 1'b1; lsu_op = LsuOp_LW; alu_result = 32'h500; rd_in = 5'd20;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("rst_wait.req", dmem_req, 1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("rst_wait.busy", ex_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait.req_dropped", dmem_req, 0);
    chk("rst_wait.ex_ready", ex_ready, 1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD_F00D;
    wb_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      dmem_rvalid = 1'b0;
      if (wb_valid) wb_seen++;
    end
    chk("rst_wait.late_rvalid_wb", wb_seen, 0);

    // Reset while requesting a store with no grant
    @(negedge clk);
    ex_valid = 1'b1; lsu_op = LsuOp_SW; alu_result = 32'h600; store_data = 32'h1;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("rst_req.req", dmem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_req.req_dropped", dmem_req, 0);
    chk("rst_req.ex_ready", ex_ready, 1);

    // Randomized ops against the model
    for (int n = 0; n < 60; n++) begin
      txn_t t;
      t.op = 4'($urandom_range(0, 15));
      t.addr = $urandom; t.sd = $urandom; t.rdata = $urandom; t.rd = 5'($urandom);
      t.gnt_dly = $urandom_range(0, 3);
      t.rv_dly = $urandom_range(0, 4);
      run_op(t, o);
      compare($sformatf("rand%0d", n), o, model(t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
